// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Multi-cycle unsigned subtractor: d = (a - b - bin) mod 2^WIDTH, with
//   bout = 1 iff a < b + bin. Processes DIGIT bits per clock, LSB slice
//   first, holding the ripple borrow in a register between slices.
//   Input and output use independent valid/ready handshakes, but a new
//   operand set is only taken once the previous result has been consumed.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 1)
//   DIGIT  bits processed per clock (must divide WIDTH)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   a, b, bin are valid
//   in_ready   block can accept operands (registered)
//   bin        borrow in
//   a, b       minuend / subtrahend, unsigned
//   out_valid  d and bout are valid (registered)
//   out_ready  consumer accepts the result
//   d          difference (registered, held after handshake)
//   bout       borrow out (registered)
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject illegal parameterisations at elaboration time.
  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One DIGIT-wide slice of subtraction; the MSB of the DIGIT+1-bit result
  // is the outgoing borrow (the two's-complement sign of the slice result).
  function automatic logic [DIGIT:0] sub_slice(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             bi
  );
    sub_slice = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
  endfunction

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  a_r, a_s;
  logic [WIDTH-1:0]  b_r, b_s;
  logic [WIDTH-1:0]  res_r, res_s;
  logic              borrow_r, borrow_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [WIDTH-1:0]  d_r, d_s;
  logic              bout_r, bout_s;
  logic              in_ready_r, in_ready_s;
  logic              out_valid_r, out_valid_s;

  logic [DIGIT:0]    slice_s;
  logic [WIDTH-1:0]  slice_top_s;
  logic [WIDTH-1:0]  res_shift_s;

  // Slice datapath: subtract the low slice and splice it in at the MSB end.
  always_comb begin
    slice_s     = sub_slice(a_r[DIGIT-1:0], b_r[DIGIT-1:0], borrow_r);
    slice_top_s = WIDTH'(slice_s[DIGIT-1:0]) << (WIDTH - DIGIT);
    res_shift_s = (res_r >> DIGIT) | slice_top_s;
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_s     = state_r;
    a_s         = a_r;
    b_s         = b_r;
    res_s       = res_r;
    borrow_s    = borrow_r;
    cnt_s       = cnt_r;
    d_s         = d_r;
    bout_s      = bout_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_s        = a;
          b_s        = b;
          borrow_s   = bin;
          cnt_s      = {CW{1'b0}};
          in_ready_s = 1'b0;
          state_s    = RUN;
        end else begin
          state_s    = IDLE;
        end
      end
      RUN: begin
        a_s      = a_r >> DIGIT;
        b_s      = b_r >> DIGIT;
        res_s    = res_shift_s;
        borrow_s = slice_s[DIGIT];
        cnt_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        // Last slice: publish the finished result straight from the shifter.
        if (cnt_r == CW'(N - 1)) begin
          d_s         = res_shift_s;
          bout_s      = slice_s[DIGIT];
          out_valid_s = 1'b1;
          state_s     = DONE;
        end else begin
          state_s     = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s     = DONE;
        end
      end
      default: begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
        state_s     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      borrow_r    <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      bout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      a_r         <= a_s;
      b_r         <= b_s;
      res_r       <= res_s;
      borrow_r    <= borrow_s;
      cnt_r       <= cnt_s;
      d_r         <= d_s;
      bout_r      <= bout_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign d         = d_r;
  assign bout      = bout_r;

endmodule
